result_collector: RTL and testbench

- Downstream stage of the 3-input priority arbiter wrapper in priority_calc.
- Consumes the arbitrated result stream: result, result_valid, one-hot result_unit, and returns result_ack.
- Buffers accepted results in a small FIFO, tags each entry with a 2-bit unit index, and presents them on a valid/ready output port.
- Keeps per-unit saturating acceptance counters and a sticky error flag for illegal unit codes.

---
 rtl/priority_calc_pkg.sv | 12 +
 rtl/result_collector_fifo.sv | 34 +++
 rtl/result_collector.sv | 63 ++++++
 tb/tb_result_collector.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/priority_calc_pkg.sv
// priority_calc_pkg: unit codes, unit index type and one-hot decode shared by the arbiter and the result collector
package priority_calc_pkg;
  localparam logic [2:0] UNIT_A = 3'b001;
  localparam logic [2:0] UNIT_B = 3'b010;
  localparam logic [2:0] UNIT_C = 3'b100;
  typedef logic [1:0] unit_idx_t;
  function automatic logic [2:0] onehot_to_idx(input logic [2:0] u);
    return u == UNIT_A ? {1'b1, 2'd0} :
           u == UNIT_B ? {1'b1, 2'd1} :
           u == UNIT_C ? {1'b1, 2'd2} : 3'b000;
  endfunction
endpackage

// File: rtl/result_collector_fifo.sv
// result_fifo: show-ahead FIFO with wrap-bit pointers and a registered occupancy count
module result_fifo #(
  parameter int W = 66,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      level <= push && !pop ? level + 1'b1 : !push && pop ? level - 1'b1 : level;
    end
endmodule

// File: rtl/result_collector.sv
// result_collector: buffers arbitrated results with unit tags, counts accepts per unit and flags illegal unit codes
module result_collector
  import priority_calc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  input  logic [2:0]               in_unit,
  output logic                     in_ack,
  output logic [WIDTH-1:0]         out_data,
  output unit_idx_t                out_unit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         cnt_a,
  output logic [CNT_W-1:0]         cnt_b,
  output logic [CNT_W-1:0]         cnt_c,
  input  logic                     cnt_clr,
  output logic                     err_unit,
  input  logic                     err_clr
);
  logic [2:0] dec;
  logic accept, push, pop, full, empty;
  logic [WIDTH+1:0] rdata;
  assign dec = onehot_to_idx(in_unit);
  assign in_ack = !full;
  assign accept = in_valid && in_ack;
  assign push = accept && dec[2];
  assign pop = out_valid && out_ready;
  assign out_valid = !empty;
  assign {out_unit, out_data} = rdata;
  result_fifo #(.W(WIDTH + 2), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .wdata({dec[1:0], in_data}),
    .rdata(rdata),
    .full(full),
    .empty(empty),
    .level(level)
  );
  function automatic logic [CNT_W-1:0] cnt_nxt(input logic [CNT_W-1:0] c, input logic inc, input logic clr);
    return clr ? CNT_W'(inc) : c + CNT_W'(inc && !(&c));
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
      cnt_c <= '0;
      err_unit <= 1'b0;
    end else begin
      cnt_a <= cnt_nxt(cnt_a, push && dec[1:0] == 2'd0, cnt_clr);
      cnt_b <= cnt_nxt(cnt_b, push && dec[1:0] == 2'd1, cnt_clr);
      cnt_c <= cnt_nxt(cnt_c, push && dec[1:0] == 2'd2, cnt_clr);
      err_unit <= (accept && !dec[2]) || (err_unit && !err_clr);
    end
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: directed table, corner sequences and random traffic against a queue-based reference model
module tb_result_collector;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;
  logic clk = 0;
  logic rst_n = 0;
  logic [WIDTH-1:0] in_data = '0;
  logic in_valid = 0;
  logic [2:0] in_unit = '0;
  logic out_ready = 0;
  logic cnt_clr = 0;
  logic err_clr = 0;
  logic in_ack, out_valid, err_unit;
  logic [WIDTH-1:0] out_data;
  logic [1:0] out_unit;
  logic [LW-1:0] level;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic s_ack, s_valid, s_err;
  logic [WIDTH-1:0] s_data;
  logic [1:0] s_unit;
  logic [LW-1:0] s_level;
  logic [1:0] s_cnt_a, s_cnt_b, s_cnt_c;
  result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_unit(in_unit),
    .in_ack(in_ack), .out_data(out_data), .out_unit(out_unit), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c),
    .cnt_clr(cnt_clr), .err_unit(err_unit), .err_clr(err_clr)
  );
  result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_unit(in_unit),
    .in_ack(s_ack), .out_data(s_data), .out_unit(s_unit), .out_valid(s_valid),
    .out_ready(out_ready), .level(s_level), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b), .cnt_c(s_cnt_c),
    .cnt_clr(cnt_clr), .err_unit(s_err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  logic [63:0] mq_data[$];
  logic [1:0] mq_unit[$];
  int mc[3];
  logic merr = 0;
  typedef struct {
    logic v; logic [2:0] u; logic [63:0] d; logic r; logic ec;
    logic [2:0] lvl; logic ack; logic vld; logic err; logic [63:0] head; logic [1:0] hu; logic [15:0] cb;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int sat(input int c, input int mx);
    return c > mx ? mx : c;
  endfunction
  task automatic model_reset();
    mq_data.delete();
    mq_unit.delete();
    for (int k = 0; k < 3; k++) mc[k] = 0;
    merr = 0;
  endtask
  task automatic check_model();
    chk("in_ack", in_ack, mq_data.size() < DEPTH);
    chk("out_valid", out_valid, mq_data.size() > 0);
    chk("level", level, mq_data.size());
    if (mq_data.size() > 0) begin
      chk("out_data", out_data, mq_data[0]);
      chk("out_unit", out_unit, mq_unit[0]);
      chk("sat_out_data", s_data, mq_data[0]);
    end
    chk("cnt_a", cnt_a, sat(mc[0], 65535));
    chk("cnt_b", cnt_b, sat(mc[1], 65535));
    chk("cnt_c", cnt_c, sat(mc[2], 65535));
    chk("sat_cnt_a", s_cnt_a, sat(mc[0], 3));
    chk("sat_cnt_b", s_cnt_b, sat(mc[1], 3));
    chk("sat_cnt_c", s_cnt_c, sat(mc[2], 3));
    chk("err_unit", err_unit, merr);
    chk("sat_level", s_level, mq_data.size());
  endtask
  task automatic cycle(input logic v, input logic [2:0] u, input logic [63:0] d, input logic r, input logic cc, input logic ec);
    logic acc, legal, popf, inc;
    int idx;
    in_valid = v; in_unit = u; in_data = d; out_ready = r; cnt_clr = cc; err_clr = ec;
    acc = v && mq_data.size() < DEPTH;
    legal = u == 3'b001 || u == 3'b010 || u == 3'b100;
    idx = u == 3'b001 ? 0 : u == 3'b010 ? 1 : 2;
    popf = r && mq_data.size() > 0;
    if (popf) begin
      void'(mq_data.pop_front());
      void'(mq_unit.pop_front());
    end
    if (acc && legal) begin
      mq_data.push_back(d);
      mq_unit.push_back(2'(idx));
    end
    for (int k = 0; k < 3; k++) begin
      inc = acc && legal && idx == k;
      mc[k] = cc ? int'(inc) : mc[k] + int'(inc);
    end
    merr = (acc && !legal) || (merr && !ec);
    @(posedge clk);
    #1;
    check_model();
  endtask
  initial begin
    int maxl;
    logic [2:0] u;
    tbl[0] = '{1'b1, 3'b001, 64'h11, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 64'h11, 2'd0, 16'd0};
    tbl[1] = '{1'b1, 3'b010, 64'h22, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 64'h11, 2'd0, 16'd1};
    tbl[2] = '{1'b1, 3'b100, 64'h33, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 64'h11, 2'd0, 16'd1};
    tbl[3] = '{1'b1, 3'b001, 64'h44, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 64'h11, 2'd0, 16'd1};
    tbl[4] = '{1'b1, 3'b010, 64'h55, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 64'h22, 2'd1, 16'd1};
    tbl[5] = '{1'b1, 3'b011, 64'h66, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 64'h22, 2'd1, 16'd1};
    tbl[6] = '{1'b0, 3'b000, 64'h00, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 64'h22, 2'd1, 16'd1};
    tbl[7] = '{1'b1, 3'b111, 64'h77, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 64'h22, 2'd1, 16'd1};
    tbl[8] = '{1'b0, 3'b000, 64'h00, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 64'h22, 2'd1, 16'd1};
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_level", level, 0);
    check_model();
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].v, tbl[i].u, tbl[i].d, tbl[i].r, 1'b0, tbl[i].ec);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("tbl%0d_ack", i), in_ack, tbl[i].ack);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_err", i), err_unit, tbl[i].err);
      chk($sformatf("tbl%0d_head", i), out_data, tbl[i].head);
      chk($sformatf("tbl%0d_unit", i), out_unit, tbl[i].hu);
      chk($sformatf("tbl%0d_cnt_b", i), cnt_b, tbl[i].cb);
    end
    rst_n = 0;
    model_reset();
    #1;
    chk("async_level", level, 0);
    chk("async_valid", out_valid, 1'b0);
    chk("async_cnt_a", cnt_a, 0);
    chk("async_cnt_b", cnt_b, 0);
    check_model();
    #3;
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_reset_ack", in_ack, 1'b1);
    check_model();
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'b010, 64'hb0 + 64'(i), 1'b1, 1'b0, 1'b0);
    chk("sat_b_wide", cnt_b, 5);
    chk("sat_b_narrow", s_cnt_b, 3);
    cycle(1'b1, 3'b010, 64'hbf, 1'b1, 1'b1, 1'b0);
    chk("clr_inc_b", cnt_b, 1);
    chk("clr_inc_b_narrow", s_cnt_b, 1);
    chk("clr_other_a", cnt_a, 0);
    maxl = 0;
    for (int i = 0; i < 14; i++) begin
      u = 3'b001 << (i % 3);
      cycle(i < 10, u, 64'h1000 + 64'(i), 1'b1, 1'b0, 1'b0);
      if (int'(level) > maxl) maxl = int'(level);
    end
    chk("stream_max_level", maxl <= 2, 1'b1);
    chk("stream_drained", out_valid, 1'b0);
    for (int i = 0; i < 600; i++) begin
      u = $urandom_range(0, 9) < 8 ? 3'b001 << $urandom_range(0, 2) : 3'($urandom);
      cycle($urandom_range(0, 3) != 0, u, {$urandom, $urandom}, 1'($urandom),
            $urandom_range(0, 40) == 0, $urandom_range(0, 20) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
